// File: rtl/segment_scan_driver.sv
// -----------------------------------------------------------------------------
// segment_scan_driver
//
// Time-multiplexed driver for a common-cathode style 7-segment display made of
// NUM_FIELDS two-digit fields. Each field is a 6-bit binary value (0..63) that
// is shown as two decimal digits: the even digit carries the ones, the odd
// digit carries the tens. One digit is enabled at a time for SCAN_DIV clocks.
// A full pass over all digits is a frame.
//
// The field values come from a shadow register that only reloads at frame
// boundaries, so a value never tears across the digits of one frame. Fields
// can blink (on/off every BLINK_FRAMES frames) and tens digits can be
// suppressed when the value is below 10. All outputs are registered.
//
// Parameters
//   NUM_FIELDS   : number of 6-bit fields, 1..4 (digits = 2*NUM_FIELDS)
//   SCAN_DIV     : clocks each digit stays enabled, >= 2
//   BLINK_FRAMES : frames per blink phase, >= 1
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   data_show  in   field k in bits [6k+5:6k], unsigned 0..63
//   blink_mask in   bit k set: field k blinks
//   blank_tens in   suppress tens digits of values below 10
//   dp_mask    in   decimal point enable per digit
//   digit_sel  out  one-hot digit enable, active high
//   segment    out  {g,f,e,d,c,b,a}, active high
//   dp         out  decimal point
//   frame_done out  one-cycle pulse after the last digit of each frame
// -----------------------------------------------------------------------------
module segment_scan_driver #(
    parameter int NUM_FIELDS   = 2,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [6*NUM_FIELDS-1:0]   data_show,
    input  logic [NUM_FIELDS-1:0]     blink_mask,
    input  logic                      blank_tens,
    input  logic [2*NUM_FIELDS-1:0]   dp_mask,
    output logic [2*NUM_FIELDS-1:0]   digit_sel,
    output logic [6:0]                segment,
    output logic                      dp,
    output logic                      frame_done
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int NUM_DIGITS = 2 * NUM_FIELDS;
    localparam int PRESC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int FIELD_W    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int FRAME_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    // -------------------------------------------------------------------------
    // Digit to segment pattern, bit order {g,f,e,d,c,b,a}
    // -------------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h00;  // unreachable for 0..63 inputs
        endcase
        return pattern;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PRESC_W-1:0]      presc_q,        presc_d;
    logic [IDX_W-1:0]        idx_q,          idx_d;
    logic [6*NUM_FIELDS-1:0] shadow_q,       shadow_d;
    logic [FRAME_W-1:0]      frame_cnt_q,    frame_cnt_d;
    logic                    blink_phase_q,  blink_phase_d;
    logic                    load_pending_q, load_pending_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q,    digit_sel_d;
    logic [6:0]              segment_q,      segment_d;
    logic                    dp_q,           dp_d;
    logic                    frame_done_q,   frame_done_d;

    // Scan timing
    logic tc;
    logic frame_wrap;

    // Display path for the digit currently addressed by idx_q
    logic [FIELD_W-1:0] field_idx;
    logic [5:0]         field_val;
    logic               field_blink;
    logic               is_tens;
    logic [3:0]         tens;
    logic [5:0]         tens_x10;
    logic [3:0]         ones;
    logic [3:0]         digit_val;
    logic               blank;

    // -------------------------------------------------------------------------
    // Scan counters, shadow load and blink phase
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        presc_d        = presc_q;
        idx_d          = idx_q;
        shadow_d       = shadow_q;
        frame_cnt_d    = frame_cnt_q;
        blink_phase_d  = blink_phase_q;
        load_pending_d = 1'b0;

        tc         = (presc_q == PRESC_LAST);
        frame_wrap = tc && (idx_q == IDX_LAST);

        if (tc) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // The shadow only moves between frames, plus once right after reset
        // so the first real frame does not have to wait a whole frame of zeros.
        if (load_pending_q || frame_wrap) begin
            shadow_d = data_show;
        end

        if (frame_wrap) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d   = frame_cnt_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Digit content: pick the field, split it into tens/ones, decide blanking
    // -------------------------------------------------------------------------
    always_comb begin
        field_idx   = FIELD_W'(idx_q >> 1);
        is_tens     = idx_q[0];
        field_val   = '0;
        field_blink = 1'b0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (field_idx == FIELD_W'(k)) begin
                field_val   = shadow_q[6*k +: 6];
                field_blink = blink_mask[k];
            end
        end

        // Values top out at 63, so a short compare ladder replaces a divider.
        tens     = 4'd0;
        tens_x10 = 6'd0;
        for (int t = 1; t <= 6; t++) begin
            if (field_val >= 6'(10 * t)) begin
                tens     = 4'(t);
                tens_x10 = 6'(10 * t);
            end
        end
        ones = 4'(field_val - tens_x10);

        digit_val = is_tens ? tens : ones;

        // Tens suppression looks at the shadowed value, the same one being
        // shown, so it can never disagree with the digits on the display.
        blank = (blink_phase_q && field_blink)
             || (is_tens && blank_tens && (field_val < 6'd10));

        // The digit stays enabled while blanked, keeping the scan duty cycle
        // identical for every digit.
        digit_sel_d          = '0;
        digit_sel_d[idx_q]   = 1'b1;
        segment_d            = blank ? 7'h00 : seg_decode(digit_val);
        dp_d                 = !blank && dp_mask[idx_q];
        frame_done_d         = frame_wrap;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the shadow is a handful of flops, not a memory, so it is reset
    // along with everything else and the first displayed frame is defined.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q        <= '0;
            idx_q          <= '0;
            shadow_q       <= '0;
            frame_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            load_pending_q <= 1'b1;
            digit_sel_q    <= '0;
            segment_q      <= '0;
            dp_q           <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_phase_q  <= blink_phase_d;
            load_pending_q <= load_pending_d;
            digit_sel_q    <= digit_sel_d;
            segment_q      <= segment_d;
            dp_q           <= dp_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign digit_sel  = digit_sel_q;
    assign segment    = segment_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_segment_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_segment_scan_driver
//
// Scoreboard bench for segment_scan_driver with NUM_FIELDS=2, SCAN_DIV=4,
// BLINK_FRAMES=2. The stimulus process drives inputs on a fixed timeline and
// queues the hand-computed digit (digit_sel, segment, dp) the display must
// present next. The monitor pops an entry whenever a new digit appears and
// checks frame_done against the 16-clock frame timing.
// -----------------------------------------------------------------------------
module tb_segment_scan_driver;

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [11:0] data_show;
    logic [1:0]  blink_mask;
    logic        blank_tens;
    logic [3:0]  dp_mask;
    logic [3:0]  digit_sel;
    logic [6:0]  segment;
    logic        dp;
    logic        frame_done;

    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;
    int   since_rst = 0;
    int   pulses   = 0;
    exp_t exp_q[$];

    segment_scan_driver #(
        .NUM_FIELDS  (2),
        .SCAN_DIV    (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .data_show (data_show),
        .blink_mask(blink_mask),
        .blank_tens(blank_tens),
        .dp_mask   (dp_mask),
        .digit_sel (digit_sel),
        .segment   (segment),
        .dp        (dp),
        .frame_done(frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [3:0] s, input logic [6:0] g, input logic d);
        exp_q.push_back({s, g, d});
    endtask

    // One full frame; only digit 0 ever carries a decimal point in these runs.
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic dp0);
        push(4'b0001, s0, dp0);
        push(4'b0010, s1, 1'b0);
        push(4'b0100, s2, 1'b0);
        push(4'b1000, s3, 1'b0);
    endtask

    // edge_n counts rising edges since reset release; inputs change on the
    // falling edge that follows rising edge k.
    task automatic advance_to(input int k);
        while (edge_n < k) begin
            @(negedge clock);
            edge_n++;
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    initial begin : monitor
        logic [11:0] prev;
        logic [11:0] cur;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                since_rst = 0;
            end else begin
                since_rst++;
                check("frame_done", 32'(frame_done), 32'((since_rst % 16) == 0));
                if (frame_done) begin
                    pulses++;
                    check("frame_done_last_digit", 32'(digit_sel), 32'h8);
                end
            end
            cur = {digit_sel, segment, dp};
            if (!reset && (cur != prev) && (digit_sel != 4'b0000)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_digit: got sel=%b seg=%h dp=%b, required no output (t=%0t)",
                             digit_sel, segment, dp, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("digit_sel", 32'(digit_sel), 32'(e.sel));
                    check("segment",   32'(segment),   32'(e.seg));
                    check("dp",        32'(dp),        32'(e.dp));
                end
            end
            prev = cur;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin : stimulus
        reset      = 1'b1;
        data_show  = {6'd12, 6'd47};
        blink_mask = 2'b00;
        blank_tens = 1'b0;
        dp_mask    = 4'b0000;
        repeat (3) @(negedge clock);

        check("reset_digit_sel",  32'(digit_sel),  32'h0);
        check("reset_segment",    32'(segment),    32'h0);
        check("reset_dp",         32'(dp),         32'h0);
        check("reset_frame_done", 32'(frame_done), 32'h0);

        // First edge shows digit 0 of the zeroed shadow, then real data.
        push(4'b0001, 7'h3F, 1'b0);
        push_frame(7'h07, 7'h66, 7'h5B, 7'h06, 1'b0);   // frame 0: 12 / 47
        push_frame(7'h07, 7'h66, 7'h5B, 7'h06, 1'b0);   // frame 1: data change mid-frame ignored
        push_frame(7'h6F, 7'h6D, 7'h3F, 7'h00, 1'b0);   // frame 2: 0 / 59, tens of 0 suppressed
        push_frame(7'h4F, 7'h7D, 7'h6D, 7'h00, 1'b0);   // frame 3: 5 / 63, tens of 5 suppressed
        push_frame(7'h4F, 7'h7D, 7'h6D, 7'h3F, 1'b1);   // frame 4: blink phase 0
        push_frame(7'h4F, 7'h7D, 7'h6D, 7'h3F, 1'b1);   // frame 5
        push_frame(7'h00, 7'h00, 7'h6D, 7'h3F, 1'b0);   // frame 6: field 0 blinked off
        push_frame(7'h00, 7'h00, 7'h6D, 7'h3F, 1'b0);   // frame 7
        push_frame(7'h4F, 7'h7D, 7'h6D, 7'h3F, 1'b1);   // frame 8: visible again
        push(4'b0001, 7'h4F, 1'b1);                     // frame 9, cut by reset
        push(4'b0010, 7'h7D, 1'b0);
        push(4'b0100, 7'h6D, 1'b0);

        #2 reset = 1'b0;
        edge_n = 0;

        advance_to(21);                 // idx = 1 of frame 1
        data_show  = {6'd0, 6'd59};

        advance_to(37);                 // idx = 1 of frame 2
        blank_tens = 1'b1;
        data_show  = {6'd5, 6'd63};

        advance_to(64);                 // between frame 3 and frame 4
        blank_tens = 1'b0;
        blink_mask = 2'b01;
        dp_mask    = 4'b0001;

        advance_to(153);                // frame 9: idx = 2, prescaler = 1
        #2 reset = 1'b1;
        #1;
        check("async_reset_digit_sel",  32'(digit_sel),  32'h0);
        check("async_reset_segment",    32'(segment),    32'h0);
        check("async_reset_dp",         32'(dp),         32'h0);
        check("async_reset_frame_done", 32'(frame_done), 32'h0);

        data_show  = {6'd23, 6'd38};
        blink_mask = 2'b00;
        dp_mask    = 4'b0000;
        repeat (2) @(negedge clock);

        push(4'b0001, 7'h3F, 1'b0);
        push_frame(7'h7F, 7'h4F, 7'h4F, 7'h5B, 1'b0);   // 23 / 38
        push_frame(7'h7F, 7'h4F, 7'h4F, 7'h5B, 1'b0);
        push(4'b0001, 7'h7F, 1'b0);

        #2 reset = 1'b0;
        edge_n = 0;
        advance_to(34);
        #1;

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        check("frame_done_pulses",  32'(pulses),       32'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
